mcu_command_decoder: RTL

Decodes the byte stream delivered by the MCU bus front end (command/data bytes with single-cycle strobes, all in the `system_clock` domain) into framebuffer pixel writes and palette writes. It sits directly downstream of the MCU bus interface and upstream of the framebuffer writer and palette RAM. It tracks the current command, assembles multi-byte arguments, auto-increments addresses and buffers pixel writes in a small FIFO with a valid/ready handshake toward the framebuffer.

---
 rtl/mcu_command_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mcu_command_decoder.sv
// Turns MCU command/data byte strobes into buffered framebuffer pixel writes and palette
// writes, with auto-incrementing addresses and sticky protocol/overflow error flags.
module mcu_command_decoder #(
  parameter int ADDRESS_WIDTH = 19,
  parameter int FRAME_SIZE    = 307200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     command_clock,
  input  logic [7:0]               command,
  input  logic                     data_clock,
  input  logic [7:0]               data,
  output logic                     pixel_valid,
  input  logic                     pixel_ready,
  output logic [ADDRESS_WIDTH-1:0] pixel_address,
  output logic [7:0]               pixel_data,
  output logic                     palette_write_enable,
  output logic [7:0]               palette_index,
  output logic [23:0]              palette_rgb,
  output logic                     busy,
  output logic                     protocol_error,
  output logic                     overflow,
  input  logic                     error_clear
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR   = ADDRESS_WIDTH'(FRAME_SIZE - 1);
  localparam logic [23:0]              FRAME_LIMIT = 24'(FRAME_SIZE);
  localparam logic [CNT_W-1:0]         FULL_CNT    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SET_ADDRESS, WRITE_PIXELS, SET_PALETTE} state_t;

  state_t                   state_q;
  logic [1:0]               byte_cnt_q;
  logic [15:0]              addr_low_q;
  logic [ADDRESS_WIDTH-1:0] pix_addr_q;
  logic [7:0]               pal_idx_q, red_q, green_q;
  logic                     palette_we_q;
  logic [7:0]               palette_index_q;
  logic [23:0]              palette_rgb_q;
  logic                     protocol_error_q, overflow_q, busy_q;

  logic [ADDRESS_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [7:0]               fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q, count_d;

  logic                     pop, push_req, push_ok, fifo_full, partial_cmd;
  logic [23:0]              new_addr;
  logic [ADDRESS_WIDTH-1:0] pix_addr_inc;

  assign pixel_valid  = (count_q != '0);
  assign fifo_full    = (count_q == FULL_CNT);
  assign pop          = pixel_valid && pixel_ready;
  assign push_req     = data_clock && !command_clock && (state_q == WRITE_PIXELS);
  assign push_ok      = push_req && (!fifo_full || pop);
  assign new_addr     = {data, addr_low_q};
  assign pix_addr_inc = (pix_addr_q == LAST_ADDR) ? '0 : pix_addr_q + ADDRESS_WIDTH'(1);
  // Palette counts 0=index,1=R,2=G,3=B; only a half-received triplet counts as partial.
  assign partial_cmd  = ((state_q == SET_ADDRESS) && (byte_cnt_q != 2'd0)) ||
                        ((state_q == SET_PALETTE) && byte_cnt_q[1]);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
  end

  assign pixel_address        = pixel_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign pixel_data           = pixel_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign palette_write_enable = palette_we_q;
  assign palette_index        = palette_index_q;
  assign palette_rgb          = palette_rgb_q;
  assign busy                 = busy_q;
  assign protocol_error       = protocol_error_q;
  assign overflow             = overflow_q;

  always_ff @(posedge system_clock) begin
    if (push_ok) begin
      fifo_addr_q[wr_ptr_q] <= pix_addr_q;
      fifo_data_q[wr_ptr_q] <= data;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q          <= IDLE;
      byte_cnt_q       <= 2'd0;
      addr_low_q       <= '0;
      pix_addr_q       <= '0;
      pal_idx_q        <= '0;
      red_q            <= '0;
      green_q          <= '0;
      palette_we_q     <= 1'b0;
      palette_index_q  <= '0;
      palette_rgb_q    <= '0;
      protocol_error_q <= 1'b0;
      overflow_q       <= 1'b0;
      busy_q           <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      palette_we_q <= 1'b0;
      count_q      <= count_d;
      busy_q       <= (count_d != '0);
      if (push_ok) begin
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
        pix_addr_q <= pix_addr_inc;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // Clear first so that any set below in the same cycle takes precedence.
      if (error_clear) begin
        protocol_error_q <= 1'b0;
        overflow_q       <= 1'b0;
      end
      if (push_req && !push_ok) overflow_q <= 1'b1;

      if (command_clock) begin
        byte_cnt_q <= 2'd0;
        if (partial_cmd || data_clock) protocol_error_q <= 1'b1;
        case (command)
          8'h00:   state_q <= IDLE;
          8'h01:   state_q <= SET_ADDRESS;
          8'h02:   state_q <= WRITE_PIXELS;
          8'h03:   state_q <= SET_PALETTE;
          default: begin
            state_q          <= IDLE;
            protocol_error_q <= 1'b1;
          end
        endcase
      end else if (data_clock) begin
        case (state_q)
          IDLE: protocol_error_q <= 1'b1;
          SET_ADDRESS: begin
            case (byte_cnt_q)
              2'd0: begin
                addr_low_q[7:0] <= data;
                byte_cnt_q      <= 2'd1;
              end
              2'd1: begin
                addr_low_q[15:8] <= data;
                byte_cnt_q       <= 2'd2;
              end
              default: begin
                byte_cnt_q <= 2'd0;
                state_q    <= IDLE;
                if (new_addr >= FRAME_LIMIT) begin
                  pix_addr_q       <= '0;
                  protocol_error_q <= 1'b1;
                end else begin
                  pix_addr_q <= ADDRESS_WIDTH'(new_addr);
                end
              end
            endcase
          end
          WRITE_PIXELS: ;
          SET_PALETTE: begin
            case (byte_cnt_q)
              2'd0: begin
                pal_idx_q  <= data;
                byte_cnt_q <= 2'd1;
              end
              2'd1: begin
                red_q      <= data;
                byte_cnt_q <= 2'd2;
              end
              2'd2: begin
                green_q    <= data;
                byte_cnt_q <= 2'd3;
              end
              default: begin
                palette_we_q    <= 1'b1;
                palette_index_q <= pal_idx_q;
                palette_rgb_q   <= {red_q, green_q, data};
                pal_idx_q       <= pal_idx_q + 8'd1;
                byte_cnt_q      <= 2'd1;
              end
            endcase
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
